// File: rtl/jtframe_resync_pkg.sv
// jtframe_resync_pkg: shared state type, offset limits and arithmetic helpers
// for the sync offset controller.
package jtframe_resync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE
  } state_e;

  localparam int OFS_W   = 4;
  localparam int OFS_MAX = 7;
  localparam int OFS_MIN = -8;

  // A step past either limit leaves the offset where it is.
  function automatic logic signed [OFS_W-1:0] sat_add4(
    input logic signed [OFS_W-1:0] a,
    input logic signed [1:0]       d
  );
    logic signed [OFS_W:0] s;
    s = {a[OFS_W-1], a} + {{(OFS_W-1){d[1]}}, d};
    if (s > OFS_MAX || s < OFS_MIN)
      return a;
    return s[OFS_W-1:0];
  endfunction

  // Last press wins; opposite presses together cancel the axis.
  function automatic logic signed [1:0] axis_merge(
    input logic signed [1:0] cur,
    input logic              inc,
    input logic              dec
  );
    if (inc && dec) return 2'sd0;
    if (inc)        return 2'sd1;
    if (dec)        return -2'sd1;
    return cur;
  endfunction

endpackage

// File: rtl/jtframe_resync_btn.sv
// jtframe_resync_btn: press detector for one button; adds frame-based
// auto-repeat when JTFRAME_RESYNC_AUTOREP_EN is defined.
module jtframe_resync_btn #(
  parameter bit AUTOREP   = 1'b1,
  parameter int REP_DELAY = 20,
  parameter int REP_RATE  = 4
)(
  input  logic clk,
  input  logic rst_n,
  input  logic cen,
  input  logic enable,
  input  logic tick,
  input  logic btn,
  output logic press
);

  logic last;
  logic edge_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   last <= 1'b0;
    else if (cen) last <= btn;
  end

  assign edge_p = cen & enable & btn & ~last;

`ifdef JTFRAME_RESYNC_AUTOREP_EN
  logic [5:0] cnt;
  logic [5:0] cnt_inc;
  logic       rep;

  assign cnt_inc = cnt + 6'd1;
  assign rep = AUTOREP && cen && tick && enable && btn
            && (cnt_inc == 6'(REP_DELAY));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cen) begin
      if (!AUTOREP || !btn || !enable) cnt <= '0;
      else if (rep)  cnt <= 6'(REP_DELAY - REP_RATE);
      else if (tick) cnt <= cnt_inc;
    end
  end

  assign press = edge_p | rep;
`else
  localparam int unused_p = REP_DELAY + REP_RATE + int'(AUTOREP);
  logic unused_tick;
  assign unused_tick = tick;
  assign press = edge_p;
`endif

endmodule

// File: rtl/jtframe_resync_ctrl.sv
// jtframe_resync_ctrl: applies OSD offset requests at vertical blank start,
// then waits a settle window. Auto-repeat: JTFRAME_RESYNC_AUTOREP_EN.
module jtframe_resync_ctrl
  import jtframe_resync_pkg::*;
#(
  parameter int SETTLE_FRAMES = 2,
  parameter int REP_DELAY     = 20,
  parameter int REP_RATE      = 4
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pxl_cen,
  input  logic       LVBL,
  input  logic       enable,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       btn_lf,
  input  logic       btn_rt,
  input  logic       btn_clr,
  output logic [3:0] hoffset,
  output logic [3:0] voffset,
  output logic       busy,
  output logic       changed
);

  state_e st, st_nx;
  logic   last_lvbl;
  logic   tick;
  logic   p_up, p_dn, p_lf, p_rt, p_clr;

  logic signed [1:0] pend_h, pend_v;
  logic signed [1:0] base_h, base_v;
  logic signed [1:0] pend_h_nx, pend_v_nx;
  logic              pend_clr, pend_clr_nx;
  logic              any_pend;

  logic [3:0]              settle_cnt, settle_nx;
  logic signed [OFS_W-1:0] hofs, vofs, h_nx, v_nx;
  logic                    chg_nx;

  assign tick = pxl_cen & last_lvbl & ~LVBL;

  jtframe_resync_btn #(
    .AUTOREP(1'b1), .REP_DELAY(REP_DELAY), .REP_RATE(REP_RATE)
  ) u_up (
    .clk(clk), .rst_n(rst_n), .cen(pxl_cen), .enable(enable),
    .tick(tick), .btn(btn_up), .press(p_up)
  );

  jtframe_resync_btn #(
    .AUTOREP(1'b1), .REP_DELAY(REP_DELAY), .REP_RATE(REP_RATE)
  ) u_dn (
    .clk(clk), .rst_n(rst_n), .cen(pxl_cen), .enable(enable),
    .tick(tick), .btn(btn_dn), .press(p_dn)
  );

  jtframe_resync_btn #(
    .AUTOREP(1'b1), .REP_DELAY(REP_DELAY), .REP_RATE(REP_RATE)
  ) u_lf (
    .clk(clk), .rst_n(rst_n), .cen(pxl_cen), .enable(enable),
    .tick(tick), .btn(btn_lf), .press(p_lf)
  );

  jtframe_resync_btn #(
    .AUTOREP(1'b1), .REP_DELAY(REP_DELAY), .REP_RATE(REP_RATE)
  ) u_rt (
    .clk(clk), .rst_n(rst_n), .cen(pxl_cen), .enable(enable),
    .tick(tick), .btn(btn_rt), .press(p_rt)
  );

  jtframe_resync_btn #(
    .AUTOREP(1'b0), .REP_DELAY(REP_DELAY), .REP_RATE(REP_RATE)
  ) u_clr (
    .clk(clk), .rst_n(rst_n), .cen(pxl_cen), .enable(enable),
    .tick(tick), .btn(btn_clr), .press(p_clr)
  );

  // Presses on this cycle are merged before the IDLE decision.
  always_comb begin
    base_h      = (st == ST_APPLY) ? 2'sd0 : pend_h;
    base_v      = (st == ST_APPLY) ? 2'sd0 : pend_v;
    pend_h_nx   = axis_merge(base_h, p_rt, p_lf);
    pend_v_nx   = axis_merge(base_v, p_dn, p_up);
    pend_clr_nx = (pend_clr && st != ST_APPLY) || p_clr;
    if (!enable) begin
      pend_h_nx   = 2'sd0;
      pend_v_nx   = 2'sd0;
      pend_clr_nx = 1'b0;
    end
    any_pend = pend_clr_nx || pend_h_nx != 2'sd0 || pend_v_nx != 2'sd0;
  end

  always_comb begin
    st_nx     = st;
    settle_nx = settle_cnt;
    h_nx      = hofs;
    v_nx      = vofs;
    chg_nx    = 1'b0;
    unique case (st)
      ST_IDLE: begin
        if (tick && any_pend) st_nx = ST_APPLY;
      end
      ST_APPLY: begin
        if (pend_clr) begin
          h_nx = '0;
          v_nx = '0;
        end else begin
          h_nx = sat_add4(hofs, pend_h);
          v_nx = sat_add4(vofs, pend_v);
        end
        chg_nx    = (h_nx != hofs) || (v_nx != vofs);
        settle_nx = 4'(SETTLE_FRAMES);
        st_nx     = (SETTLE_FRAMES == 0) ? ST_IDLE : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (tick) begin
          settle_nx = settle_cnt - 4'd1;
          if (settle_cnt <= 4'd1) st_nx = ST_IDLE;
        end
      end
      default: st_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= ST_IDLE;
      settle_cnt <= '0;
      hofs       <= '0;
      vofs       <= '0;
      changed    <= 1'b0;
      pend_h     <= 2'sd0;
      pend_v     <= 2'sd0;
      pend_clr   <= 1'b0;
      last_lvbl  <= 1'b1;
    end else if (pxl_cen) begin
      st         <= st_nx;
      settle_cnt <= settle_nx;
      hofs       <= h_nx;
      vofs       <= v_nx;
      changed    <= chg_nx;
      pend_h     <= pend_h_nx;
      pend_v     <= pend_v_nx;
      pend_clr   <= pend_clr_nx;
      last_lvbl  <= LVBL;
    end
  end

  assign hoffset = hofs;
  assign voffset = vofs;
  assign busy    = (st != ST_IDLE);

endmodule

// File: tb/tb_jtframe_resync_ctrl.sv
// tb_jtframe_resync_ctrl: vector table, directed corner sequences and a
// randomized frame-level run against a behavioural offset model.
module tb_jtframe_resync_ctrl;

  localparam int SETTLE = 2;
  localparam logic [4:0] M_RT  = 5'b00001;
  localparam logic [4:0] M_LF  = 5'b00010;
  localparam logic [4:0] M_DN  = 5'b00100;
  localparam logic [4:0] M_UP  = 5'b01000;
  localparam logic [4:0] M_CLR = 5'b10000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pxl_cen = 1'b1;
  logic LVBL = 1'b1;
  logic enable = 1'b1;
  logic btn_up = 1'b0, btn_dn = 1'b0, btn_lf = 1'b0;
  logic btn_rt = 1'b0, btn_clr = 1'b0;
  logic [3:0] hoffset, voffset;
  logic busy, changed;

  int n_tot = 0;
  int n_pass = 0;
  int chg_total = 0;
  int base;

  typedef struct {
    logic [4:0] mask;
    int h;
    int v;
    int chg;
  } vec_t;
  vec_t tbl[14];

  // frame-level model
  int m_h, m_v, m_ph, m_pv, m_cool;
  bit m_pc;

  always #5 clk = ~clk;

  jtframe_resync_ctrl #(.SETTLE_FRAMES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LVBL(LVBL),
    .enable(enable), .btn_up(btn_up), .btn_dn(btn_dn),
    .btn_lf(btn_lf), .btn_rt(btn_rt), .btn_clr(btn_clr),
    .hoffset(hoffset), .voffset(voffset), .busy(busy),
    .changed(changed)
  );

  always @(negedge clk) if (changed) chg_total++;

  function automatic int hv(input logic [3:0] x);
    return int'($signed(x));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input logic [4:0] m);
    {btn_clr, btn_up, btn_dn, btn_lf, btn_rt} = m;
  endtask

  task automatic press(input logic [4:0] m);
    set_btn(m);
    cyc();
    set_btn(5'd0);
    cyc();
  endtask

  // Blank start (tick) plus enough cycles for the apply to land.
  task automatic frame_start(input logic [4:0] tick_mask);
    base = chg_total;
    LVBL = 1'b0;
    set_btn(tick_mask);
    cyc();
    set_btn(5'd0);
    cyc(); cyc(); cyc();
    LVBL = 1'b1;
    cyc();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy; i++) frame_start(5'd0);
    chk("wait_idle", int'(busy), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_btn(5'd0);
    LVBL = 1'b1;
    enable = 1'b1;
    pxl_cen = 1'b1;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  function automatic int sat(input int a, input int d);
    int s;
    s = a + d;
    return (s > 7 || s < -8) ? a : s;
  endfunction

  task automatic m_press(input logic [4:0] m);
    if (m[0] && m[1]) m_ph = 0;
    else if (m[0])    m_ph = 1;
    else if (m[1])    m_ph = -1;
    if (m[2] && m[3]) m_pv = 0;
    else if (m[2])    m_pv = 1;
    else if (m[3])    m_pv = -1;
    if (m[4]) m_pc = 1'b1;
  endtask

  task automatic m_tick(output int chg);
    int nh, nv;
    chg = 0;
    if (m_cool > 0) begin
      m_cool--;
    end else if (m_pc || m_ph != 0 || m_pv != 0) begin
      nh = m_pc ? 0 : sat(m_h, m_ph);
      nv = m_pc ? 0 : sat(m_v, m_pv);
      chg = (nh != m_h || nv != m_v) ? 1 : 0;
      m_h = nh;
      m_v = nv;
      m_ph = 0;
      m_pv = 0;
      m_pc = 1'b0;
      m_cool = SETTLE;
    end
  endtask

  initial begin
    int ec;
    logic [4:0] m;
    bit en;

    for (int i = 0; i < 7; i++) tbl[i] = '{M_RT, i + 1, 0, 1};
    tbl[7]  = '{M_RT, 7, 0, 0};
    tbl[8]  = '{M_LF | M_RT, 7, 0, 0};
    tbl[9]  = '{M_UP, 7, -1, 1};
    tbl[10] = '{M_UP | M_DN | M_LF, 6, -1, 1};
    tbl[11] = '{M_CLR, 0, 0, 1};
    tbl[12] = '{M_CLR, 0, 0, 0};
    tbl[13] = '{M_UP | M_CLR, 0, 0, 0};

    cyc(); cyc();
    chk("rst_h", hv(hoffset), 0);
    chk("rst_v", hv(voffset), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_changed", int'(changed), 0);
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < 14; i++) begin
      wait_idle();
      press(tbl[i].mask);
      frame_start(5'd0);
      chk($sformatf("tbl%0d_h", i), hv(hoffset), tbl[i].h);
      chk($sformatf("tbl%0d_v", i), hv(voffset), tbl[i].v);
      chk($sformatf("tbl%0d_chg", i), chg_total - base, tbl[i].chg);
    end

    for (int i = 1; i <= 9; i++) begin
      wait_idle();
      press(M_LF);
      frame_start(5'd0);
      chk("lf_min_h", hv(hoffset), (i > 8) ? -8 : -i);
      chk("lf_min_chg", chg_total - base, (i > 8) ? 0 : 1);
    end

    // settle window length
    wait_idle();
    press(M_RT);
    frame_start(5'd0);
    chk("settle_h", hv(hoffset), -7);
    chk("settle_busy0", int'(busy), 1);
    for (int k = 1; k <= SETTLE; k++) begin
      frame_start(5'd0);
      chk("settle_busy", int'(busy), (k < SETTLE) ? 1 : 0);
    end

    // press on the tick cycle counts for that tick
    frame_start(M_RT);
    chk("same_tick_h", hv(hoffset), -6);
    chk("same_tick_chg", chg_total - base, 1);

    // requests latched during settle apply after it ends
    do_reset();
    foreach (tbl[i]) begin end
    for (int i = 0; i < 5; i++) begin
      wait_idle();
      press((i < 3) ? M_RT : M_UP);
      frame_start(5'd0);
    end
    chk("pre_h", hv(hoffset), 3);
    chk("pre_v", hv(voffset), -2);
    press(M_CLR | M_UP);
    frame_start(5'd0);
    chk("hold1_h", hv(hoffset), 3);
    chk("hold1_busy", int'(busy), 1);
    frame_start(5'd0);
    chk("hold2_v", hv(voffset), -2);
    chk("hold2_busy", int'(busy), 0);
    chk("hold2_chg", chg_total - base, 0);
    frame_start(5'd0);
    chk("clr_h", hv(hoffset), 0);
    chk("clr_v", hv(voffset), 0);
    chk("clr_chg", chg_total - base, 1);

    // asynchronous reset in the middle of settle
    wait_idle();
    press(M_DN);
    frame_start(5'd0);
    chk("dn_v", hv(voffset), 1);
    press(M_RT);
    rst_n = 1'b0;
    #2;
    chk("arst_h", hv(hoffset), 0);
    chk("arst_v", hv(voffset), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_changed", int'(changed), 0);
    #1;
    rst_n = 1'b1;
    cyc();
    base = chg_total;
    for (int i = 0; i < 3; i++) frame_start(5'd0);
    chk("post_rst_h", hv(hoffset), 0);
    chk("post_rst_v", hv(voffset), 0);
    chk("post_rst_busy", int'(busy), 0);

    // enable low drops pending requests
    press(M_RT);
    enable = 1'b0;
    cyc();
    enable = 1'b1;
    frame_start(5'd0);
    chk("en_h", hv(hoffset), 0);
    chk("en_busy", int'(busy), 0);

    // nothing moves without pxl_cen
    pxl_cen = 1'b0;
    LVBL = 1'b0;
    set_btn(M_RT);
    cyc(); cyc(); cyc();
    chk("cen_h", hv(hoffset), 0);
    chk("cen_busy", int'(busy), 0);
    set_btn(5'd0);
    LVBL = 1'b1;
    cyc();
    pxl_cen = 1'b1;
    frame_start(5'd0);
    chk("cen2_h", hv(hoffset), 0);
    chk("cen2_busy", int'(busy), 0);

    // randomized frames against the model
    do_reset();
    m_h = 0; m_v = 0; m_ph = 0; m_pv = 0; m_pc = 1'b0; m_cool = 0;
    for (int f = 0; f < 200; f++) begin
      en = ($urandom_range(0, 7) != 0);
      enable = en;
      if (!en) begin
        m_ph = 0; m_pv = 0; m_pc = 1'b0;
      end
      frame_start(5'd0);
      m_tick(ec);
      chk("rnd_h", hv(hoffset), m_h);
      chk("rnd_v", hv(voffset), m_v);
      chk("rnd_busy", int'(busy), (m_cool > 0) ? 1 : 0);
      chk("rnd_chg", chg_total - base, ec);
      for (int e = 0; e < int'($urandom_range(0, 2)); e++) begin
        m = 5'($urandom_range(0, 15));
        if ($urandom_range(0, 5) == 0) m = m | M_CLR;
        press(m);
        if (en) m_press(m);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
